// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit: Booth radix-2 multiply and restoring
// divide, one iteration per clock, results on hi/lo with a start/busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_C = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + ONE_C;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   m_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic             q1_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;
    logic             fix_dz_s;

    // Booth add/subtract of the multiplicand selected by the {q0, q-1} pair
    always_comb begin
        booth_sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b10:   booth_sum_s = acc_r - m_r;
            2'b01:   booth_sum_s = acc_r + m_r;
            default: booth_sum_s = acc_r;
        endcase
    end

    // Restoring-divide trial subtraction on the left-shifted remainder
    always_comb begin
        rem_shift_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        trial_s     = {1'b0, rem_shift_s} - {1'b0, m_r};
    end

    // Final sign correction / unsigned-multiply correction applied in FIX
    always_comb begin
        fix_hi_s = acc_r[WIDTH-1:0];
        fix_lo_s = q_r;
        fix_dz_s = 1'b0;
        if (op_r[1]) begin
            if (b_r == ZERO_C) begin
                fix_dz_s = 1'b1;
                fix_hi_s = a_r;
                fix_lo_s = ONES_C;
            end else if (!op_r[0]) begin
                fix_lo_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? neg(q_r) : q_r;
                fix_hi_s = a_r[WIDTH-1] ? neg(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            end else begin
                fix_hi_s = acc_r[WIDTH-1:0];
                fix_lo_s = q_r;
            end
        end else begin
            // Booth treats the multiplier MSB as negative weight; multu adds it back
            fix_hi_s = acc_r[WIDTH-1:0] + ((op_r[0] && b_r[WIDTH-1]) ? a_r : ZERO_C);
            fix_lo_s = q_r;
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= 2'b00;
            a_r        <= ZERO_C;
            b_r        <= ZERO_C;
            m_r        <= {(WIDTH+1){1'b0}};
            acc_r      <= {(WIDTH+1){1'b0}};
            q_r        <= ZERO_C;
            q1_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= ZERO_C;
            lo_r       <= ZERO_C;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= S_RUN;
                        busy_r     <= 1'b1;
                        div_zero_r <= 1'b0;
                        cnt_r      <= {CW{1'b0}};
                        op_r       <= op;
                        a_r        <= A;
                        b_r        <= B;
                        acc_r      <= {(WIDTH+1){1'b0}};
                        q1_r       <= 1'b0;
                        if (op[1]) begin
                            m_r <= {1'b0, magnitude(B, !op[0])};
                            q_r <= magnitude(A, !op[0]);
                        end else begin
                            m_r <= op[0] ? {1'b0, A} : {A[WIDTH-1], A};
                            q_r <= B;
                        end
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (op_r[1]) begin
                        if (!trial_s[WIDTH+1]) begin
                            acc_r <= trial_s[WIDTH:0];
                            q_r   <= {q_r[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_r <= rem_shift_s;
                            q_r   <= {q_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_r <= {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
                        q_r   <= {booth_sum_s[0], q_r[WIDTH-1:1]};
                        q1_r  <= q_r[0];
                    end
                    if (cnt_r == LAST_C) begin
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    state_r    <= S_DONE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    hi_r       <= fix_hi_s;
                    lo_r       <= fix_lo_s;
                    div_zero_r <= fix_dz_s;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int   checks = 0;
    int   fails = 0;
    int   lat;
    logic seq_err;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Issue one op (immediately if now=1, else at the next negedge) and wait for done.
    // lat = cycle of done counting the first cycle after the sampling edge as 1.
    task automatic do_op(input logic now, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi0, lo0;
        if (!now) @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; lat = 1; seq_err = 1'b0; hi0 = hi; lo0 = lo;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || hi !== hi0 || lo !== lo0) seq_err = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) seq_err = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({busy, done, div_zero, hi, lo} !== 67'h0) begin fails++; $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        do_op(1'b0, 2'b00, 32'd7, 32'hFFFFFFFD);
        checks++; if (lat !== 34) begin fails++; $display("FAIL mult_latency: got %0d want 34", lat); end
        checks++; if (seq_err !== 1'b0) begin fails++; $display("FAIL mult_busy_hold: got %b want 0", seq_err); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        do_op(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_max_lo: got %h want 00000001", lo); end
        do_op(1'b0, 2'b00, 32'h80000000, 32'h80000000);
        checks++; if (hi !== 32'h40000000) begin fails++; $display("FAIL mult_minmin_hi: got %h want 40000000", hi); end
        checks++; if (lo !== 32'h00000000) begin fails++; $display("FAIL mult_minmin_lo: got %h want 00000000", lo); end
    endtask

    task automatic test_div();
        do_op(1'b0, 2'b10, 32'hFFFFFFF9, 32'd2);
        checks++; if (lat !== 34) begin fails++; $display("FAIL div_latency: got %0d want 34", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        do_op(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin fails++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL div_ovf_dz: got %b want 0", div_zero); end
        do_op(1'b0, 2'b11, 32'hFFFFFFFF, 32'h10);
        checks++; if (lo !== 32'h0FFFFFFF) begin fails++; $display("FAIL divu_lo: got %h want 0fffffff", lo); end
        checks++; if (hi !== 32'h0000000F) begin fails++; $display("FAIL divu_hi: got %h want 0000000f", hi); end
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 2'b11, 32'd7, 32'd0);
        checks++; if (lat !== 34) begin fails++; $display("FAIL dz_latency: got %0d want 34", lat); end
        checks++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd7) begin fails++; $display("FAIL dz_hi: got %h want 00000007", hi); end
        @(negedge clk);
        checks++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_held: got %b want 1", div_zero); end
        do_op(1'b0, 2'b10, 32'hFFFFFFFB, 32'd0);
        checks++; if (hi !== 32'hFFFFFFFB) begin fails++; $display("FAIL dz_signed_hi: got %h want fffffffb", hi); end
        checks++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_signed_flag: got %b want 1", div_zero); end
        do_op(1'b0, 2'b11, 32'd100, 32'd7);
        checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL dz_cleared: got %b want 0", div_zero); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL divu_100_7: got hi=%h lo=%h want 2/e", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int extra;
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd6;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5 || lat == 20) begin
                start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 34) begin fails++; $display("FAIL ignore_latency: got %0d want 34", lat); end
        checks++; if ({hi, lo} !== {32'd0, 32'd30}) begin fails++; $display("FAIL ignore_result: got hi=%h lo=%h want 0/1e", hi, lo); end
        do_op(1'b1, 2'b01, 32'd9, 32'd9);
        checks++; if (lat !== 34) begin fails++; $display("FAIL b2b_latency: got %0d want 34", lat); end
        checks++; if ({hi, lo} !== {32'd0, 32'd81}) begin fails++; $display("FAIL b2b_result: got hi=%h lo=%h want 0/51", hi, lo); end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL b2b_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_async_reset();
        logic saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, done, div_zero, hi, lo} !== 67'h0) begin fails++; $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo); end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin fails++; $display("FAIL reset_abort: got activity=%b want 0", saw_done); end
        do_op(1'b0, 2'b00, 32'd3, 32'd4);
        checks++; if (lat !== 34) begin fails++; $display("FAIL post_reset_latency: got %0d want 34", lat); end
        checks++; if ({hi, lo} !== {32'd0, 32'd12}) begin fails++; $display("FAIL post_reset_mult: got hi=%h lo=%h want 0/c", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
